// File: rtl/fx_exp_rr_arbiter.sv
// Round-robin arbiter sharing one exp unit among N_REQ requesters, in-order return via a tag FIFO.
// Optional counters stat_grants/stat_stall are built when FX_EXP_ARB_STATS_EN is defined.

package fpga_cfg_pkg;
    localparam int FP_WIDTH = 32;
    localparam int QFRAC    = 16;
endpackage

module fx_exp_rr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = fpga_cfg_pkg::FP_WIDTH,
    parameter int TAG_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]       rsp_result,
    output logic                   exp_valid,
    input  logic                   exp_ready,
    output logic [WIDTH-1:0]       exp_a,
    input  logic                   exp_rvalid,
    output logic                   exp_rready,
    input  logic [WIDTH-1:0]       exp_result
`ifdef FX_EXP_ARB_STATS_EN
    ,
    output logic [N_REQ*32-1:0]    stat_grants,
    output logic [31:0]            stat_stall
`endif
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  gnt;
    logic [ID_W-1:0]  idx;
    logic [ID_W-1:0]  head;
    logic             found;
    logic             any_valid;
    logic             full;
    logic             not_empty;
    logic             live;
    logic             issue;
    logic             pop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [ID_W-1:0]  tag_mem [TAG_DEPTH];
    logic [WIDTH-1:0] req_a_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign req_a_arr[i] = req_a[i*WIDTH +: WIDTH];
    end

    // First valid requester at or after rr_ptr, wrapping
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    assign any_valid = |req_valid;
    assign full      = (count == CNT_W'(TAG_DEPTH));
    assign not_empty = (count != '0);
    assign live      = not_empty && !rst;
    assign head      = tag_mem[rd_ptr];

    // A pop in the same cycle never frees a slot for a push
    assign issue = any_valid && exp_ready && !full && !rst;
    assign pop   = exp_rvalid && exp_rready;

    assign exp_valid  = issue;
    assign exp_a      = req_a_arr[gnt];
    assign exp_rready = live && rsp_ready[head];
    assign rsp_result = exp_result;

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (issue) begin
            req_ready[gnt] = 1'b1;
        end
        if (live && exp_rvalid) begin
            rsp_valid[head] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (issue) begin
                rr_ptr <= (gnt == ID_W'(N_REQ - 1)) ? '0 : gnt + ID_W'(1);
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({issue, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem[wr_ptr] <= gnt;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && exp_rvalid) begin
            assert (not_empty)
            else $error("exp_rvalid asserted with no tag in flight");
        end
    end
`endif

`ifdef FX_EXP_ARB_STATS_EN
    for (genvar i = 0; i < N_REQ; i++) begin : g_stat
        always_ff @(posedge clk) begin
            if (rst) begin
                stat_grants[i*32 +: 32] <= '0;
            end else if (req_ready[i] && stat_grants[i*32 +: 32] != '1) begin
                stat_grants[i*32 +: 32] <= stat_grants[i*32 +: 32] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall <= '0;
        end else if (any_valid && !issue && stat_stall != '1) begin
            stat_stall <= stat_stall + 32'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_fx_exp_rr_arbiter.sv
// Bench for fx_exp_rr_arbiter: vector table, directed corner sequences, random run
// against a queue-based reference model and a behavioural variable-latency exp unit.

module tb_fx_exp_rr_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [W-1:0]   rsp_result;
    logic           exp_valid;
    logic           exp_ready;
    logic [W-1:0]   exp_a;
    logic           exp_rvalid;
    logic           exp_rready;
    logic [W-1:0]   exp_result;
`ifdef FX_EXP_ARB_STATS_EN
    logic [N*32-1:0] stat_grants;
    logic [31:0]     stat_stall;
    int              e_grants [N];
    int              e_stall;
`endif

    fx_exp_rr_arbiter #(.N_REQ(N), .WIDTH(W), .TAG_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_a(exp_a),
        .exp_rvalid(exp_rvalid), .exp_rready(exp_rready), .exp_result(exp_result)
`ifdef FX_EXP_ARB_STATS_EN
        , .stat_grants(stat_grants), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        int           due;
    } exp_op_t;

    typedef struct {
        logic [N-1:0] rv;
        logic [N-1:0] rdy;
    } vec_t;

    exp_op_t      eq [$];
    int           tags [$];
    logic [W-1:0] expq [N][$];
    int           rr;
    int           cyc;
    bit           exp_en;
    int           nvec;
    int           nerr;
    int           rsp_seen;
    logic [N-1:0] last_req_ready;
    logic [N-1:0] last_rsp_valid;
    logic [W-1:0] last_rsp_result;
    logic         last_exp_rready;

    function automatic logic [W-1:0] fx_exp(input logic [W-1:0] a);
        real r;
        r = $exp($itor($signed(a)) / 65536.0);
        return W'($rtoi(r * 65536.0));
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic logic [W-1:0] rand_a();
        return W'($urandom_range(0, 6 * 65536)) - W'(4 * 65536);
    endfunction

    function automatic void model_clear();
        eq.delete();
        tags.delete();
        foreach (expq[i]) expq[i].delete();
        rr = 0;
    endfunction

    // One clock: drive exp-unit outputs, check at negedge, update models at posedge
    task automatic step();
        int           g;
        int           h;
        bit           iss;
        bit           er_e;
        bit           pop_e;
        bit           dut_acc;
        bit           dut_pop;
        logic [N-1:0] rdy_e;
        logic [N-1:0] rv_e;
        logic [W-1:0] acc_a;
        exp_ready  = exp_en && (eq.size() < 8);
        exp_rvalid = (eq.size() > 0) && (eq[0].due <= cyc);
        exp_result = (eq.size() > 0) ? eq[0].res : '0;
        @(negedge clk);
        g = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_valid[(rr + k) % N]) g = (rr + k) % N;
        end
        iss   = (|req_valid) && exp_ready && (tags.size() < 4) && !rst;
        rdy_e = iss ? N'(1 << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(rdy_e));
        chk("exp_valid", 32'(exp_valid), 32'(iss));
        if (iss) chk("exp_a", exp_a, req_a[g*W +: W]);
        h     = (tags.size() > 0) ? tags[0] : 0;
        rv_e  = (exp_rvalid && tags.size() > 0 && !rst) ? N'(1 << h) : '0;
        er_e  = (tags.size() > 0) && !rst && rsp_ready[h];
        pop_e = exp_rvalid && er_e;
        chk("rsp_valid", 32'(rsp_valid), 32'(rv_e));
        chk("exp_rready", 32'(exp_rready), 32'(er_e));
        if (pop_e) chk("rsp_result", rsp_result, expq[h][0]);
        last_req_ready  = req_ready;
        last_rsp_valid  = rsp_valid;
        last_rsp_result = rsp_result;
        last_exp_rready = exp_rready;
        if (|(rsp_valid & rsp_ready)) rsp_seen++;
        dut_acc = exp_valid && exp_ready;
        dut_pop = exp_rvalid && exp_rready;
        acc_a   = exp_a;
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_clear();
`ifdef FX_EXP_ARB_STATS_EN
            foreach (e_grants[i]) e_grants[i] = 0;
            e_stall = 0;
`endif
        end else begin
            if (dut_pop && eq.size() > 0) void'(eq.pop_front());
            if (dut_acc) eq.push_back('{res: fx_exp(acc_a), due: cyc + LAT - 1});
            if (pop_e) begin
                void'(tags.pop_front());
                void'(expq[h].pop_front());
            end
            if (iss) begin
                tags.push_back(g);
                expq[g].push_back(fx_exp(req_a[g*W +: W]));
                rr = (g + 1) % N;
            end
`ifdef FX_EXP_ARB_STATS_EN
            if (iss) e_grants[g]++;
            if ((|req_valid) && !iss) e_stall++;
`endif
        end
        #1;
    endtask

    task automatic drain(input int n);
        req_valid = '0;
        rsp_ready = '1;
        exp_en    = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    vec_t tbl [14];

    initial begin
        int base;
        bit seen;
        nvec = 0;
        nerr = 0;
        cyc = 0;
        rsp_seen = 0;
        model_clear();
`ifdef FX_EXP_ARB_STATS_EN
        foreach (e_grants[i]) e_grants[i] = 0;
        e_stall = 0;
`endif
        tbl[0]  = '{4'b1111, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b0010};
        tbl[2]  = '{4'b0000, 4'b0000};
        tbl[3]  = '{4'b1010, 4'b1000};
        tbl[4]  = '{4'b1010, 4'b0010};
        tbl[5]  = '{4'b0001, 4'b0001};
        tbl[6]  = '{4'b0100, 4'b0100};
        tbl[7]  = '{4'b0111, 4'b0001};
        tbl[8]  = '{4'b1001, 4'b1000};
        tbl[9]  = '{4'b1111, 4'b0001};
        tbl[10] = '{4'b1111, 4'b0010};
        tbl[11] = '{4'b1111, 4'b0100};
        tbl[12] = '{4'b1111, 4'b1000};
        tbl[13] = '{4'b1111, 4'b0001};

        rst        = 1'b1;
        req_valid  = '1;
        rsp_ready  = '1;
        exp_en     = 1'b1;
        exp_ready  = 1'b0;
        exp_rvalid = 1'b0;
        exp_result = '0;
        for (int i = 0; i < N; i++) req_a[i*W +: W] = rand_a();
        #1;
        step();
        step();
        rst = 1'b0;

        foreach (tbl[i]) begin
            req_valid = tbl[i].rv;
            for (int r = 0; r < N; r++) req_a[r*W +: W] = rand_a();
            step();
            chk($sformatf("tbl%0d_grant", i), 32'(last_req_ready), 32'(tbl[i].rdy));
        end

        drain(6);
        req_valid = 4'b0100;
        req_a[2*W +: W] = '0;
        step();
        chk("one_req_issue", 32'(last_req_ready), 32'(4'b0100));
        req_valid = '0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            if (last_rsp_valid != '0) begin
                seen = 1'b1;
                chk("one_req_rsp_valid", 32'(last_rsp_valid), 32'(4'b0100));
                chk("one_req_exp0", last_rsp_result, 32'h0001_0000);
            end
        end
        chk("one_req_timeout", 32'(seen), 32'd1);

        drain(6);
        base = rsp_seen;
        req_valid = '1;
        rsp_ready = '0;
        for (int i = 0; i < 6; i++) begin
            for (int r = 0; r < N; r++) req_a[r*W +: W] = rand_a();
            step();
        end
        chk("full_blocks_req", 32'(last_req_ready), 32'd0);
        chk("stalled_rready", 32'(last_exp_rready), 32'd0);
        drain(12);
        chk("no_loss_count", 32'(rsp_seen - base), 32'd4);

        drain(6);
        req_valid = '1;
        rsp_ready = '0;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        step();
        chk("rst_req_ready", 32'(last_req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(last_rsp_valid), 32'd0);
        rst = 1'b0;
        rsp_ready = '1;
        step();
        chk("post_rst_grant0", 32'(last_req_ready), 32'(4'b0001));
        chk("post_rst_rready", 32'(last_exp_rready), 32'd0);

        for (int i = 0; i < 400; i++) begin
            req_valid = N'($urandom);
            for (int r = 0; r < N; r++) begin
                req_a[r*W +: W] = rand_a();
                rsp_ready[r] = ($urandom_range(0, 3) != 0);
            end
            exp_en = ($urandom_range(0, 4) != 0);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        drain(12);

`ifdef FX_EXP_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            chk($sformatf("stat_grants%0d", i), stat_grants[i*32 +: 32], 32'(e_grants[i]));
        end
        chk("stat_stall", stat_stall, 32'(e_stall));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
